// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive input sweep comparing reference and simplified functions
module truth_table_checker #(
    parameter int N  = 3,
    parameter int F  = 5,
    parameter int CW = N + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop_on_fail,
    output logic [N-1:0]  vec,
    input  logic [F-1:0]  ref_val,
    input  logic [F-1:0]  dut_val,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_count,
    output logic [F-1:0]  fail_mask,
    output logic [N-1:0]  first_vec,
    output logic          first_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [N-1:0]  VEC_LAST = {N{1'b1}};
    localparam logic [N-1:0]  VEC_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] ERR_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [CW-1:0] err_count_q, err_count_d;
    logic [F-1:0]  fail_mask_q, fail_mask_d;
    logic [N-1:0]  first_vec_q, first_vec_d;
    logic          first_valid_q, first_valid_d;
    logic          pass_q, pass_d;
    logic          stop_latched_q, stop_latched_d;
    logic [F-1:0]  diff;

    assign diff = ref_val ^ dut_val;

    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        err_count_d    = err_count_q;
        fail_mask_d    = fail_mask_q;
        first_vec_d    = first_vec_q;
        first_valid_d  = first_valid_q;
        pass_d         = pass_q;
        stop_latched_d = stop_latched_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d        = SWEEP;
                    vec_d          = '0;
                    err_count_d    = '0;
                    fail_mask_d    = '0;
                    first_vec_d    = '0;
                    first_valid_d  = 1'b0;
                    pass_d         = 1'b0;
                    stop_latched_d = stop_on_fail;
                end
            end
            SWEEP: begin
                fail_mask_d = fail_mask_q | diff;
                if (|diff) begin
                    err_count_d = err_count_q + ERR_ONE;
                    if (!first_valid_q) begin
                        first_vec_d   = vec_q;
                        first_valid_d = 1'b1;
                    end
                end
                // vec is left on the last compared vector when the sweep ends
                if ((vec_q == VEC_LAST) || ((|diff) && stop_latched_q)) begin
                    state_d = DONE;
                    pass_d  = (err_count_d == '0);
                end else begin
                    vec_d = vec_q + VEC_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            vec_q          <= '0;
            err_count_q    <= '0;
            fail_mask_q    <= '0;
            first_vec_q    <= '0;
            first_valid_q  <= 1'b0;
            pass_q         <= 1'b0;
            stop_latched_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            err_count_q    <= err_count_d;
            fail_mask_q    <= fail_mask_d;
            first_vec_q    <= first_vec_d;
            first_valid_q  <= first_valid_d;
            pass_q         <= pass_d;
            stop_latched_q <= stop_latched_d;
        end
    end

    assign vec         = vec_q;
    assign busy        = (state_q == SWEEP);
    assign done        = (state_q == DONE);
    assign pass        = pass_q;
    assign err_count   = err_count_q;
    assign fail_mask   = fail_mask_q;
    assign first_vec   = first_vec_q;
    assign first_valid = first_valid_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - randomized and directed sweeps against a table-driven model
module tb_truth_table_checker;

    localparam int N  = 3;
    localparam int F  = 5;
    localparam int CW = N + 1;
    localparam int NV = 1 << N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop_on_fail = 1'b0;
    logic [N-1:0]  vec;
    logic [F-1:0]  ref_val;
    logic [F-1:0]  dut_val;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] err_count;
    logic [F-1:0]  fail_mask;
    logic [N-1:0]  first_vec;
    logic          first_valid;

    logic [F-1:0] ref_tab [NV];
    logic [F-1:0] flt_tab [NV];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // functions under test: a reference table and the same table with per-vector faults flipped
    assign ref_val = ref_tab[vec];
    assign dut_val = ref_tab[vec] ^ flt_tab[vec];

    truth_table_checker #(.N(N), .F(F), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
        .vec(vec), .ref_val(ref_val), .dut_val(dut_val),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_mask(fail_mask), .first_vec(first_vec), .first_valid(first_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < NV; i++) flt_tab[i] = '0;
    endtask

    task automatic random_tables();
        for (int i = 0; i < NV; i++) begin
            ref_tab[i] = F'($urandom);
            flt_tab[i] = ($urandom_range(0, 3) == 0) ? F'($urandom) : '0;
        end
    endtask

    // Runs one sweep from IDLE/DONE and checks every cycle against the fault table.
    task automatic run_sweep(input bit sof, input bit repulse);
        int len;
        int e_err;
        logic [F-1:0] e_mask;
        int e_first;
        bit e_fv;
        len = NV;
        for (int j = 0; j < NV; j++) begin
            if (sof && flt_tab[j] != '0 && len == NV) len = j + 1;
        end
        e_err = 0; e_mask = '0; e_first = 0; e_fv = 0;

        @(negedge clk);
        start = 1'b1;
        stop_on_fail = sof;
        @(negedge clk);
        start = 1'b0;
        stop_on_fail = ($urandom_range(0, 1) == 1);
        for (int c = 0; c < len; c++) begin
            chk("busy", busy, 1);
            chk("done_in_sweep", done, 0);
            chk("pass_in_sweep", pass, 0);
            chk("vec", vec, c);
            chk("err_count_run", err_count, e_err);
            chk("fail_mask_run", fail_mask, e_mask);
            chk("first_valid_run", first_valid, e_fv);
            if (flt_tab[c] != '0) begin
                e_err++;
                if (!e_fv) begin e_fv = 1; e_first = c; end
            end
            e_mask = e_mask | flt_tab[c];
            start = repulse && (c == 2);
            @(negedge clk);
            start = 1'b0;
        end
        for (int h = 0; h < 2; h++) begin
            chk("done", done, 1);
            chk("busy_done", busy, 0);
            chk("vec_final", vec, len - 1);
            chk("pass", pass, (e_err == 0));
            chk("err_count", err_count, e_err);
            chk("fail_mask", fail_mask, e_mask);
            chk("first_valid", first_valid, e_fv);
            if (e_fv) chk("first_vec", first_vec, e_first);
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < NV; i++) ref_tab[i] = F'(i * 7);
        clear_faults();
        #12;
        chk("rst_vec", vec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // identity sweep, start re-pulsed mid-sweep
        run_sweep(1'b0, 1'b1);
        chk("lit_id_pass", pass, 1);
        chk("lit_id_err", err_count, 0);
        chk("lit_id_mask", fail_mask, 5'b00000);
        chk("lit_id_vec", vec, 3'b111);

        // single fault on channel 2 at vector 101
        flt_tab[5] = 5'b00100;
        run_sweep(1'b0, 1'b0);
        chk("lit_sf_pass", pass, 0);
        chk("lit_sf_err", err_count, 1);
        chk("lit_sf_mask", fail_mask, 5'b00100);
        chk("lit_sf_first", first_vec, 3'b101);
        chk("lit_sf_fv", first_valid, 1);

        clear_faults();
        flt_tab[3] = 5'b01001;
        flt_tab[6] = 5'b00001;
        flt_tab[4] = 5'b00001;
        run_sweep(1'b0, 1'b0);
        chk("lit_mf_err", err_count, 3);
        chk("lit_mf_mask", fail_mask, 5'b01001);
        chk("lit_mf_first", first_vec, 3'b011);

        run_sweep(1'b1, 1'b0);
        chk("lit_sof_vec", vec, 3'b011);
        chk("lit_sof_err", err_count, 1);
        chk("lit_sof_mask", fail_mask, 5'b01001);

        // restart from DONE clears results
        clear_faults();
        run_sweep(1'b0, 1'b0);
        chk("lit_restart_err", err_count, 0);

        // async reset mid-sweep at vec=100
        flt_tab[1] = 5'b10000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4; c++) @(negedge clk);
        chk("pre_rst_vec", vec, 3'b100);
        #2 rst = 1'b1;
        #1;
        chk("arst_vec", vec, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pass", pass, 0);
        chk("arst_err", err_count, 0);
        chk("arst_mask", fail_mask, 0);
        chk("arst_first", first_vec, 0);
        chk("arst_fv", first_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        run_sweep(1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            random_tables();
            run_sweep($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking sweep engine for combinational logic under test. It drives every one of the 2^N input vectors to up to F pairs of combinational functions, reference and simplified, one vector per clock. Each cycle it compares the two outputs of every pair and accumulates pass/fail results: mismatch count, per-channel fail mask and first failing vector. It sits beside the full-expression and simplified-expression modules in the lab designs and replaces hand-read $monitor tables with a registered verdict.

## Interface
- N, default 3: number of function inputs; sweep covers 2^N vectors.
- F, default 5: number of function pairs (channels) checked in parallel.
- CW, default N+1: error-counter width (derived; holds up to 2^N).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep. Honoured in IDLE or DONE, ignored while busy.
- stop_on_fail  in  1  mode select, sampled at start. 1 = terminate at the first failing vector.
- vec  out  N  input vector driven to all functions under test (registered).
- ref_val  in  F  reference (full expression) outputs for vec, bit i = channel i.
- dut_val  in  F  simplified-expression outputs for vec.
- busy  out  1  high in SWEEP.
- done  out  1  high in DONE; held until next start or reset.
- pass  out  1  valid while done. 1 when err_count == 0.
- err_count  out  CW  number of vectors with at least one channel mismatching.
- fail_mask  out  F  sticky OR of (ref_val ^ dut_val) over compared vectors.
- first_vec  out  N  vector of the first mismatch. Valid when first_valid = 1.
- first_valid  out  1  a mismatch has been captured this sweep.

## Operation
- States: IDLE, SWEEP, DONE.
- IDLE → SWEEP on start. vec, err_count, fail_mask, first_vec, first_valid and pass are cleared. The stop_on_fail value is latched.
- Each SWEEP cycle, mismatch is computed as diff = ref_val ^ dut_val for the current vec. On the edge:
  - fail_mask |= diff.
  - If diff != 0: err_count += 1. A vector counts once regardless of how many channels differ.
  - On the first nonzero diff: first_vec = vec and first_valid = 1.
- SWEEP → DONE when vec == 2^N−1 has been compared, or when a mismatch is compared with latched stop_on_fail = 1. Otherwise vec increments by 1.
- vec does not wrap. In DONE it holds the last compared vector.
- pass = 1 in DONE iff err_count == 0. pass is 0 outside DONE.
- DONE → SWEEP on start, with full clear. DONE persists otherwise.
- start while in SWEEP has no effect. stop_on_fail changes mid-sweep have no effect.
- ref_val and dut_val are treated as combinational functions of vec, settled within the cycle. X/Z inputs are not handled.

## Timing
- Reset, asynchronous: state IDLE. All outputs 0: vec=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, first_vec=0, first_valid=0.
- Reset asserted mid-sweep aborts immediately with the same values. A new start afterwards restarts at vec=0.
- start sampled high at edge k produces the following:
  - After edge k: busy=1 and vec=0.
  - Vector j is compared at edge k+1+j.
  - A full sweep sets done=1 and busy=0 after edge k+2^N. That is 8 cycles of busy for N=3.
- With stop_on_fail on a failing vector j: done=1 after edge k+1+j, and vec=j.
- Results update on the same edge as the compare. There is no extra pipeline stage.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Identity, N=3, F=5, dut_val = ref_val for all vectors, start pulsed once → busy for 8 cycles, then done=1, pass=1, err_count=0, fail_mask=00000, first_valid=0, vec=111.
- Single fault: dut channel 2 inverted only at vec=101 → done after 8 cycles, pass=0, err_count=1, fail_mask=00100, first_vec=101, first_valid=1.
- Multi-fault: channels 0 and 3 both wrong at vec=011, and channel 0 wrong at vec=110 and vec=100, with stop_on_fail=0 → err_count=3, fail_mask=01001, first_vec=011.
- Stop-on-fail with the same faults and stop_on_fail=1 → done after the 4th compare, vec=011, err_count=1, fail_mask=01001.
- Control edge cases:
  - start re-pulsed during SWEEP → ignored, sweep length unchanged.
  - start pulsed in DONE → all results cleared and a new 8-cycle sweep.
- Async reset asserted while vec=100 mid-sweep → all outputs 0 before the next clock edge, state IDLE. A subsequent start sweeps from vec=000 with clean counters.
